// File: rtl/referee_pkg.sv
// Shared definitions for the tug-of-war round referee.
//   state_t             : referee FSM states (PLAY, HOLD, OVER)
//   WIN_*               : encodings driven on the 2-bit winner output
//   SEG_0 .. SEG_9      : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK           : all segments off
package referee_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_digit.sv
// Combinational 4-bit to 7-segment decoder, active-low outputs.
//   value    in  4  binary digit value
//   segments out 7  {g..a}, 0 = segment lit; values above 9 are blanked
module seg7_digit
  import referee_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (value)
      4'd0: segments = SEG_0;
      4'd1: segments = SEG_1;
      4'd2: segments = SEG_2;
      4'd3: segments = SEG_3;
      4'd4: segments = SEG_4;
      4'd5: segments = SEG_5;
      4'd6: segments = SEG_6;
      4'd7: segments = SEG_7;
      4'd8: segments = SEG_8;
      4'd9: segments = SEG_9;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/round_referee.sv
// Round referee for the tug-of-war playfield: detects round wins from the
// edge lights and key pulses, keeps both scores, recentres the field after a
// short winner-hold period and freezes the game once MAX_SCORE is reached.
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   L, R           in   one-cycle key pulses (already synchronised)
//   edge_left_on   in   leftmost playfield light lit
//   edge_right_on  in   rightmost playfield light lit
//   resetround     out  recentre request to every playfield light
//   left_score     out  left player round wins
//   right_score    out  right player round wins
//   winner         out  10 = left, 01 = right, 00 = none
//   game_over      out  a player has reached MAX_SCORE
//   hex_left       out  active-low 7-segment image of left_score
//   hex_right      out  active-low 7-segment image of right_score
module round_referee
  import referee_pkg::*;
#(
  parameter int SCORE_W     = 3,
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               L,
  input  logic               R,
  input  logic               edge_left_on,
  input  logic               edge_right_on,
  output logic               resetround,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic [1:0]         winner,
  output logic               game_over,
  output logic [6:0]         hex_left,
  output logic [6:0]         hex_right
);

  localparam int                 CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MAX_VAL   = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] ONE       = SCORE_W'(1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SCORE_W-1:0] left_reg, left_next;
  logic [SCORE_W-1:0] right_reg, right_next;
  logic [1:0]         winner_reg, winner_next;

  // The two conditions exclude each other, so a simultaneous L+R never scores.
  logic left_win, right_win;
  assign left_win  = edge_left_on & L & ~R;
  assign right_win = edge_right_on & R & ~L;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= PLAY;
      cnt_reg    <= '0;
      left_reg   <= '0;
      right_reg  <= '0;
      winner_reg <= WIN_NONE;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      left_reg   <= left_next;
      right_reg  <= right_next;
      winner_reg <= winner_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    left_next   = left_reg;
    right_next  = right_reg;
    winner_next = winner_reg;
    resetround  = 1'b0;

    case (state_reg)
      PLAY: begin
        if (left_win) begin
          left_next   = left_reg + ONE;
          winner_next = WIN_LEFT;
          if (left_next == MAX_VAL) begin
            state_next = OVER;
          end else begin
            state_next = HOLD;
            cnt_next   = HOLD_LOAD;
          end
        end else if (right_win) begin
          right_next  = right_reg + ONE;
          winner_next = WIN_RIGHT;
          if (right_next == MAX_VAL) begin
            state_next = OVER;
          end else begin
            state_next = HOLD;
            cnt_next   = HOLD_LOAD;
          end
        end
      end

      // Keys and edge lights are ignored here; the counter reaching zero marks
      // the single cycle in which the light cells are told to recentre.
      HOLD: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          resetround  = 1'b1;
          state_next  = PLAY;
          winner_next = WIN_NONE;
        end
      end

      // Holding resetround keeps the field centred and frozen until reset.
      OVER: begin
        resetround = 1'b1;
      end

      default: begin
        state_next = PLAY;
      end
    endcase
  end

  assign left_score  = left_reg;
  assign right_score = right_reg;
  assign winner      = winner_reg;
  assign game_over   = (state_reg == OVER);

  // Scores never exceed 9, so truncating or zero-extending to 4 bits is lossless.
  logic [3:0] digit_val [2];
  logic [6:0] digit_seg [2];
  assign digit_val[0] = 4'(left_reg);
  assign digit_val[1] = 4'(right_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_digit
      seg7_digit u_digit (
        .value    (digit_val[gi]),
        .segments (digit_seg[gi])
      );
    end
  endgenerate

  assign hex_left  = digit_seg[0];
  assign hex_right = digit_seg[1];

endmodule

// File: doc/round_referee.md
Name: round_referee

Overview:
- Downstream stage of the tug-of-war playfield: watches the two end-of-field lights and the conditioned key pulses, detects a round win, and keeps per-player scores.
- Drives the shared resetround line back into every playfield light cell after a short winner-hold period.
- Freezes the game once a player reaches MAX_SCORE.
- Drives two active-low 7-segment score digits.

Parameters:
SCORE_W, 3, width of each score counter
MAX_SCORE, 7, score that ends the game; legal range is 1 to min(9, 2^SCORE_W-1)
HOLD_CYCLES, 4, cycles (>=1) the winner indication is held before the field recentres

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
L  in  1  left key press, already synchronised and one-cycle-pulsed
R  in  1  right key press, already synchronised and one-cycle-pulsed
edge_left_on  in  1  leftmost playfield light is lit
edge_right_on  in  1  rightmost playfield light is lit
resetround  out  1  recentre request to all playfield lights
left_score  out  SCORE_W  left player round wins
right_score  out  SCORE_W  right player round wins
winner  out  2  2'b10 = left, 2'b01 = right, 2'b00 = none
game_over  out  1  a player has reached MAX_SCORE
hex_left  out  7  active-low segments {g..a} showing left_score
hex_right  out  7  active-low segments {g..a} showing right_score

Behaviour:
- State machine states: PLAY, HOLD, OVER. All state, counter and score registers update on posedge clk.
- Reset values: state PLAY; scores 0; winner 00; game_over 0; resetround 0; hold counter 0; hex outputs 7'b1000000 (digit "0").
- reset has priority over every other input, including mid-HOLD and in OVER.
- Win detection in PLAY:
  - left_win = edge_left_on & L & ~R.
  - right_win = edge_right_on & R & ~L.
  - L and R pressed together never scores, because the two conditions are mutually exclusive.
- PLAY, on a left_win or right_win sampled at edge k:
  - At edge k: the winning score increments by 1 and winner is set.
  - If the incremented score equals MAX_SCORE, the next state is OVER.
  - Otherwise the next state is HOLD and the hold counter loads HOLD_CYCLES-1.
- PLAY with no win: all registers hold.
- HOLD:
  - L and R are ignored.
  - The counter decrements by 1 each cycle while it is nonzero.
  - resetround = 1 combinationally while state is HOLD and the counter is 0. It is high for exactly one cycle: the HOLD_CYCLES-th cycle after edge k.
  - On the next edge the state returns to PLAY and winner clears to 00. The light cells sample resetround at that same edge.
- OVER:
  - resetround is held at 1 continuously, which keeps the field centred and frozen.
  - game_over = 1.
  - winner and scores hold.
  - Keys are ignored.
  - Only reset exits OVER.
- Score arithmetic:
  - Unsigned, SCORE_W bits.
  - A score can never exceed MAX_SCORE, because reaching it forces OVER; no wrap is possible.
- hex outputs are purely combinational from the score registers. Values 0-9 map to standard digits; any other value maps to 7'b1111111 (blank).
- An edge light lit without the matching key press does not score. An edge light still lit during HOLD does not score.
- A win in the first PLAY cycle after HOLD is legal.
- Counter width: $clog2(HOLD_CYCLES+1).

Decomposition:
- Package referee_pkg holds:
  - the state enum {PLAY, HOLD, OVER};
  - winner encodings WIN_NONE / WIN_LEFT / WIN_RIGHT;
  - the 7-segment pattern constants for digits 0-9 and BLANK.
- One sub-module, seg7_digit: a combinational 4-bit to 7-segment active-low decoder, instantiated twice with scores zero-extended to 4 bits.

Test Plan:
- Reset, then idle for 5 cycles -> scores 0/0, winner 00, resetround 0, hex_left = hex_right = 7'b1000000.
- edge_left_on=1 with an L pulse -> next cycle left_score=1 and winner=10. resetround is high for exactly one cycle, 4 cycles after the win edge; then winner=00 and the state is PLAY.
- edge_right_on=1 with L and R pulsed in the same cycle -> no score change and resetround stays 0. edge_left_on=1 with an R pulse -> no score.
- During HOLD, pulse R with edge_right_on=1 -> right_score unchanged.
- Seven left wins in succession -> after the 7th, left_score=7, game_over=1, resetround held at 1, hex_left=7'b1111000. Further presses do nothing; reset returns everything to 0.
- Assert reset in the 2nd HOLD cycle -> the next cycle shows reset values, with no resetround pulse from the aborted HOLD.
